// File: rtl/alu_issue_if.sv
// Bundle between the alu_issue sequencer (master) and its environment: instruction
// source, combinational ALU, writeback observer and debug register-file port.
interface alu_issue_if;
    // Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready;
    // instr_ready depends only on sequencer state, never on instr_valid.
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [5:0]  alu_func;
    logic [31:0] alu_result;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata;
    logic [1:0]  dbg_state;

    modport master (
        input  instr_valid, instr, alu_result, dbg_raddr,
        output instr_ready, alu_a, alu_b, alu_func, wb_valid, wb_rd, wb_data,
               illegal, dbg_rdata, dbg_state
    );

    modport slave (
        output instr_valid, instr, alu_result, dbg_raddr,
        input  instr_ready, alu_a, alu_b, alu_func, wb_valid, wb_rd, wb_data,
               illegal, dbg_rdata, dbg_state
    );
endinterface

// File: rtl/alu_issue.sv
// Four-cycle MIPS R-type decode/issue sequencer with a 32x32 register file.
// Optional macro ALU_ISSUE_SHIFT_EN adds internally computed sll/srl/sra.
module alu_issue #(
    parameter logic [31:0] REG_RESET_VAL  = 32'h0000_0000,
    parameter bit          ILLEGAL_STICKY = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_issue_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [5:0]  alu_func_q, alu_func_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        illegal_q, illegal_d;
    logic [31:0] rf_q [32];
    logic        rf_we;

    logic [5:0]  opcode, func;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_val, rt_val;
    logic        is_nop, is_alu, is_shift, legal;
    logic [31:0] exec_result;

    assign opcode = instr_q[31:26];
    assign rs     = instr_q[25:21];
    assign rt     = instr_q[20:16];
    assign rd     = instr_q[15:11];
    assign func   = instr_q[5:0];

    // Entry 0 is never written, but reads are masked anyway so it always returns 0.
    assign rs_val = (rs == 5'd0) ? 32'h0 : rf_q[rs];
    assign rt_val = (rt == 5'd0) ? 32'h0 : rf_q[rt];

    always_comb begin
        is_nop = (instr_q == 32'h0);
        is_alu = (opcode == 6'd0) &&
                 ((func == 6'd32) || (func == 6'd34) || (func == 6'd36) ||
                  (func == 6'd37) || (func == 6'd43));
`ifdef ALU_ISSUE_SHIFT_EN
        is_shift = (opcode == 6'd0) &&
                   ((func == 6'd0) || (func == 6'd2) || (func == 6'd3));
`else
        is_shift = 1'b0;
`endif
        legal = is_nop | is_alu | is_shift;
    end

    // instr_q is held through EXEC, so the shift decode is still valid there.
    always_comb begin
        exec_result = bus.alu_result;
`ifdef ALU_ISSUE_SHIFT_EN
        if (is_shift) begin
            case (func)
                6'd0:    exec_result = alu_b_q << instr_q[10:6];
                6'd2:    exec_result = alu_b_q >> instr_q[10:6];
                default: exec_result = $unsigned($signed(alu_b_q) >>> instr_q[10:6]);
            endcase
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_func_d = alu_func_q;
        wb_data_d  = wb_data_q;
        illegal_d  = ILLEGAL_STICKY ? illegal_q : 1'b0;
        rf_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.instr_valid) begin
                    instr_d = bus.instr;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (legal) begin
                    alu_a_d    = rs_val;
                    alu_b_d    = rt_val;
                    alu_func_d = is_shift ? 6'd0 : func;
                    state_d    = EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            EXEC: begin
                wb_data_d = exec_result;
                state_d   = WB;
            end
            WB: begin
                rf_we   = (rd != 5'd0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            instr_q    <= 32'h0;
            alu_a_q    <= 32'h0;
            alu_b_q    <= 32'h0;
            alu_func_q <= 6'h0;
            wb_data_q  <= 32'h0;
            illegal_q  <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= (i == 0) ? 32'h0 : REG_RESET_VAL;
            end
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_func_q <= alu_func_d;
            wb_data_q  <= wb_data_d;
            illegal_q  <= illegal_d;
            if (rf_we) begin
                rf_q[rd] <= wb_data_q;
            end
        end
    end

    assign bus.instr_ready = (state_q == IDLE);
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_func    = alu_func_q;
    assign bus.wb_valid    = (state_q == WB);
    assign bus.wb_rd       = (state_q == WB) ? rd : 5'd0;
    assign bus.wb_data     = wb_data_q;
    assign bus.illegal     = illegal_q;
    assign bus.dbg_rdata   = (bus.dbg_raddr == 5'd0) ? 32'h0 : rf_q[bus.dbg_raddr];
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: model ALU, hand-computed writeback values,
// back-to-back dependent issue and asynchronous reset mid-instruction.
module tb_alu_issue;
  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  alu_issue_if bus ();

  alu_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference ALU: spec func codes (43 is nor here); anything else returns 0.
  always_comb begin
    case (bus.alu_func)
      6'd32:   bus.alu_result = bus.alu_a + bus.alu_b;
      6'd34:   bus.alu_result = bus.alu_a - bus.alu_b;
      6'd36:   bus.alu_result = bus.alu_a & bus.alu_b;
      6'd37:   bus.alu_result = bus.alu_a | bus.alu_b;
      6'd43:   bus.alu_result = ~(bus.alu_a | bus.alu_b);
      default: bus.alu_result = 32'h0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                        input int sh, input int fn);
    rtype = {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  task automatic rd_reg(input string tag, input int addr, input logic [31:0] exp);
    bus.dbg_raddr = 5'(addr);
    #1;
    check(tag, bus.dbg_rdata, exp);
  endtask

  // Drives one instruction from IDLE and checks every cycle up to its return to IDLE.
  task automatic run(input string tag, input logic [31:0] ins, input bit legal,
                     input logic [31:0] ea, input logic [31:0] eb, input int ef,
                     input int erd, input logic [31:0] ed);
    check({tag, "_ready_idle"}, 32'(bus.instr_ready), 1);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    check({tag, "_ready_decode"}, 32'(bus.instr_ready), 0);
    tick();
    if (!legal) begin
      check({tag, "_illegal_hi"}, 32'(bus.illegal), 1);
      check({tag, "_no_wb"}, 32'(bus.wb_valid), 0);
      check({tag, "_ready_after"}, 32'(bus.instr_ready), 1);
      tick();
      check({tag, "_illegal_lo"}, 32'(bus.illegal), 0);
      check({tag, "_no_wb2"}, 32'(bus.wb_valid), 0);
    end else begin
      check({tag, "_illegal_lo"}, 32'(bus.illegal), 0);
      check({tag, "_alu_a"}, bus.alu_a, ea);
      check({tag, "_alu_b"}, bus.alu_b, eb);
      check({tag, "_alu_func"}, 32'(bus.alu_func), 32'(ef));
      check({tag, "_wb_lo_exec"}, 32'(bus.wb_valid), 0);
      tick();
      check({tag, "_wb_valid"}, 32'(bus.wb_valid), 1);
      check({tag, "_wb_rd"}, 32'(bus.wb_rd), 32'(erd));
      check({tag, "_wb_data"}, bus.wb_data, ed);
      tick();
      check({tag, "_wb_lo_after"}, 32'(bus.wb_valid), 0);
      check({tag, "_ready_after"}, 32'(bus.instr_ready), 1);
      rd_reg({tag, "_rf"}, erd, (erd == 0) ? 32'h0 : ed);
    end
  endtask

  initial begin
    logic [31:0] b2b_list [3];
    int k;
    int last;

    // Reset
    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = 32'h0;
    bus.dbg_raddr   = 5'd0;
    #1;
    check("rst_ready", 32'(bus.instr_ready), 1);
    check("rst_state", 32'(bus.dbg_state), 0);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_alu_b", bus.alu_b, 0);
    check("rst_alu_func", 32'(bus.alu_func), 0);
    check("rst_wb_valid", 32'(bus.wb_valid), 0);
    check("rst_wb_rd", 32'(bus.wb_rd), 0);
    check("rst_wb_data", bus.wb_data, 0);
    check("rst_illegal", 32'(bus.illegal), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    run("add3", 32'h0022_1820, 1, 32'h0, 32'h0, 32, 3, 32'h0);
    run("nor1", rtype(0, 0, 1, 0, 43), 1, 32'h0, 32'h0, 43, 1, 32'hFFFF_FFFF);
    run("sub1", rtype(0, 1, 1, 0, 34), 1, 32'h0, 32'hFFFF_FFFF, 34, 1, 32'h1);

`ifdef ALU_ISSUE_SHIFT_EN
    run("sll2", rtype(0, 1, 2, 4, 0), 1, 32'h0, 32'h1, 0, 2, 32'h10);
    run("sll16", rtype(0, 1, 16, 31, 0), 1, 32'h0, 32'h1, 0, 16, 32'h8000_0000);
    run("sra15", rtype(0, 16, 15, 31, 3), 1, 32'h0, 32'h8000_0000, 0, 15, 32'hFFFF_FFFF);
    run("srl17", rtype(0, 16, 17, 31, 2), 1, 32'h0, 32'h8000_0000, 0, 17, 32'h1);
`else
    run("sll2", rtype(0, 1, 2, 4, 0), 0, 32'h0, 32'h0, 0, 0, 32'h0);
    run("sra15", rtype(0, 16, 15, 31, 3), 0, 32'h0, 32'h0, 0, 0, 32'h0);
    run("srl17", rtype(0, 16, 17, 31, 2), 0, 32'h0, 32'h0, 0, 0, 32'h0);
    rd_reg("sll_no_write", 2, 32'h0);
`endif

    // Build R1=5, R2=7 from chained adds
    run("add2", rtype(1, 1, 2, 0, 32), 1, 32'h1, 32'h1, 32, 2, 32'h2);
    run("add7", rtype(2, 2, 7, 0, 32), 1, 32'h2, 32'h2, 32, 7, 32'h4);
    run("add1", rtype(7, 1, 1, 0, 32), 1, 32'h4, 32'h1, 32, 1, 32'h5);
    run("add2b", rtype(1, 2, 2, 0, 32), 1, 32'h5, 32'h2, 32, 2, 32'h7);

    run("sub4", rtype(2, 1, 4, 0, 34), 1, 32'h7, 32'h5, 34, 4, 32'h2);
    run("sub5", rtype(1, 2, 5, 0, 34), 1, 32'h5, 32'h7, 34, 5, 32'hFFFF_FFFE);
    run("and6", rtype(1, 2, 6, 0, 36), 1, 32'h5, 32'h7, 36, 6, 32'h5);
    run("or8", rtype(1, 2, 8, 0, 37), 1, 32'h5, 32'h7, 37, 8, 32'h7);

    run("addu", rtype(1, 2, 9, 0, 33), 0, 32'h0, 32'h0, 0, 0, 32'h0);
    rd_reg("addu_rf9", 9, 32'h0);
    run("addi", 32'h2029_0005, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    rd_reg("addi_rf9", 9, 32'h0);
    check("alu_func_held", 32'(bus.alu_func), 37);

    run("add0", rtype(1, 2, 0, 0, 32), 1, 32'h5, 32'h7, 32, 0, 32'd12);
    run("nop", 32'h0, 1, 32'h0, 32'h0, 0, 0, 32'h0);

    // instr_valid held high: one accept every 4 cycles, dependent chain
    b2b_list[0] = rtype(1, 2, 10, 0, 32);
    b2b_list[1] = rtype(10, 1, 11, 0, 32);
    b2b_list[2] = rtype(11, 10, 12, 0, 32);
    exp_q = {32'd12, 32'd17, 32'd29};
    k    = 0;
    last = 0;
    bus.instr_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (bus.instr_ready && k < 3) begin
        if (k > 0) check("b2b_gap", 32'(c - last), 4);
        last      = c;
        bus.instr = b2b_list[k];
        k++;
      end else if (k == 3) begin
        bus.instr_valid = 1'b0;
      end
      if (bus.wb_valid) begin
        if (exp_q.size() > 0) check("b2b_wb_data", bus.wb_data, exp_q.pop_front());
        else check("b2b_extra_wb", 32'(bus.wb_valid), 0);
      end
      tick();
    end
    bus.instr_valid = 1'b0;
    check("b2b_accepts", 32'(k), 3);
    check("b2b_pending", 32'(exp_q.size()), 0);
    rd_reg("b2b_rf12", 12, 32'd29);

    // Asynchronous reset while an instruction is in EXEC
    bus.instr       = rtype(1, 2, 13, 0, 32);
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    tick();
    check("ar_in_exec", 32'(bus.dbg_state), 2);
    #2 rst_n = 1'b0;
    #1;
    check("ar_state", 32'(bus.dbg_state), 0);
    check("ar_ready", 32'(bus.instr_ready), 1);
    check("ar_alu_a", bus.alu_a, 0);
    check("ar_alu_b", bus.alu_b, 0);
    check("ar_alu_func", 32'(bus.alu_func), 0);
    check("ar_wb_valid", 32'(bus.wb_valid), 0);
    check("ar_wb_data", bus.wb_data, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("ar_no_wb", 32'(bus.wb_valid), 0);
    end
    check("ar_ready_rel", 32'(bus.instr_ready), 1);
    rd_reg("ar_rf13", 13, 32'h0);
    rd_reg("ar_rf1", 1, 32'h0);
    run("post_rst_add", 32'h0022_1820, 1, 32'h0, 32'h0, 32, 3, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Multi-cycle decode/issue sequencer on the driving side of the MIPS R-type ALU interface.
- Accepts 32-bit instructions over a valid/ready handshake and decodes them.
- Reads operands from an internal 32x32 register file and drives operand_a/operand_b/func to the combinational ALU.
- Captures the ALU result, writes it back to rd, and flags unsupported encodings as illegal.

Parameters:
- REG_RESET_VAL, 32'h0000_0000: reset value of registers 1..31. Register 0 always reads 0.
- ILLEGAL_STICKY, 0: 1 holds `illegal` high until reset; 0 pulses it for one cycle.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept an instruction.
- instr  in  32  MIPS instruction word.
- alu_a  out  32  ALU operand_a = R[rs].
- alu_b  out  32  ALU operand_b = R[rt].
- alu_func  out  6  ALU func code.
- alu_result  in  32  combinational ALU result.
- wb_valid  out  1  one-cycle writeback strobe.
- wb_rd  out  5  destination register of the completing instruction.
- wb_data  out  32  value written.
- illegal  out  1  unsupported instruction detected.
- dbg_raddr  in  5  debug register-file read address.
- dbg_rdata  out  32  R[dbg_raddr], combinational; 0 for address 0.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, instr_ready=1.
  - alu_a=0, alu_b=0, alu_func=0.
  - wb_valid=0, wb_rd=0, wb_data=0, illegal=0.
  - R[1..31]=REG_RESET_VAL.
  - Any in-flight instruction is discarded with no writeback.
- FSM: IDLE -> DECODE -> EXEC -> WB -> IDLE. One instruction in flight; throughput 1 per 4 cycles.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready at edge T0: latch instr, go to DECODE.
  - instr_ready is 0 in every other state.
- DECODE (cycle T0+1):
  - Legal = opcode instr[31:26]==0 and func instr[5:0] in {32 add, 34 sub, 36 and, 37 or, 43 nor}.
  - instr==32'h0 is a NOP and always legal: completes with wb_valid=1, wb_rd=0, no write, illegal=0.
  - Legal: at T1 register alu_a=R[rs], alu_b=R[rt], alu_func=func, go to EXEC.
  - Illegal: at T1 assert illegal (one cycle, or sticky per ILLEGAL_STICKY), no ALU drive, no writeback, go to IDLE.
- EXEC (cycle T1+1):
  - alu_* stable for the whole cycle.
  - At T2 sample alu_result into wb_data, go to WB.
- WB (cycle T2+1):
  - wb_valid=1, wb_rd=rd, wb_data valid.
  - At T3 write R[rd]=wb_data unless rd==0; go to IDLE.
  - wb_valid returns to 0 next cycle.
- alu_a/alu_b/alu_func hold their last values outside EXEC; they are never cleared except by reset.
- Latency: accept at T0 -> wb_valid high in cycle T3 -> instr_ready high again in cycle T3+1.
- Back-to-back dependent instructions read the updated register with no forwarding needed, because writeback completes before the next accept.
- instr_valid while busy: ignored, since instr_ready=0.
- A dbg_raddr read of a register being written in WB returns the old value until the T3 edge.
- All arithmetic is 32-bit wrap-around, performed by the ALU. This block never inspects or alters alu_result.

Optional Feature:
- Macro ALU_ISSUE_SHIFT_EN.
- Defined:
  - func 0 (sll), 2 (srl) and 3 (sra) are legal; shamt is instr[10:6].
  - The result is computed internally from R[rt] in EXEC and alu_result is ignored.
  - alu_func is driven 0 in EXEC for these instructions.
  - Timing is identical: 4 cycles.
- Not defined:
  - func 0/2/3 are illegal, except the all-zero NOP, which remains a NOP.

Test Plan:
- Reset with REG_RESET_VAL=0; add $3,$1,$2 (0x00221820) with a model ALU -> alu_func=32 in EXEC; wb_valid in cycle T3 with wb_rd=3, wb_data=0; dbg_rdata(3)=0.
- Preload R1=5, R2=7 via prior add results; sub $4,$2,$1 -> wb_data=2.
  - Then sub $5,$1,$2 -> wb_data=32'hFFFF_FFFE (wrap).
- addu (func 33) or opcode 8 -> illegal pulses 1 cycle at T1, no wb_valid, register file unchanged, instr_ready high at T1+1.
- add $0,$1,$2 -> wb_valid=1, wb_rd=0, R0 still reads 0. NOP 0x00000000 -> wb_valid, no illegal.
- Hold instr_valid high continuously -> exactly one accept per 4 cycles; 3 dependent adds produce correct chained results.
- Deassert rst_n asynchronously in EXEC -> outputs reset immediately, no wb_valid, instr_ready=1 after release.
  - With ALU_ISSUE_SHIFT_EN: sll $2,$1,4 with R1=1 -> wb_data=16; sra of 0x80000000 by 31 -> 0xFFFF_FFFF.
